dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage (master) and the data-memory responder (slave).
// Signal names follow the datapath's own MemRead/MemWrite/Stall naming.
interface dmem_responder_if;
  logic [3:0]  MemRead;
  logic [3:0]  MemWrite;
  logic        MemSignExtend;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Misaligned;

  // Request fields are held stable by the master while Stall=1; the responder
  // samples them in the acceptance cycle and ignores them until completion.
  // ReadData and Misaligned are meaningful only in the cycle where Stall=0
  // following (or coinciding with) an accepted request.
  modport master (
    output MemRead, MemWrite, MemSignExtend, Addr, WriteData,
    input  ReadData, Stall, Misaligned
  );

  modport slave (
    input  MemRead, MemWrite, MemSignExtend, Addr, WriteData,
    output ReadData, Stall, Misaligned
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM with wait states, little-endian lane
// alignment on stores, sign/zero extension on loads and misalignment flagging.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus,
  output logic             dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);

  function automatic logic legal_mask(input logic [3:0] m);
    return (m == 4'b0001) || (m == 4'b0011) || (m == 4'b1111);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  rd_q, wr_q;
  logic        sx_q;
  logic [31:0] addr_q, wdata_q;

  logic        wr_req, rd_req, req;
  logic [3:0]  live_rd, live_wr;
  logic        stall, complete, latch_en, use_live;

  logic [3:0]  c_rd, c_wr, c_size, be;
  logic        c_sx, mis, we;
  logic [31:0] c_addr, c_wdata, wdata_sh, rword, rsh, ld;
  logic [1:0]  off;
  logic [ADDR_WIDTH-1:0] idx;
  logic        unused_addr_hi;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Store wins over a simultaneous load; illegal masks count as no request.
  always_comb begin
    wr_req  = legal_mask(bus.MemWrite);
    rd_req  = legal_mask(bus.MemRead) && !wr_req;
    req     = wr_req || rd_req;
    live_wr = wr_req ? bus.MemWrite : 4'b0000;
    live_rd = rd_req ? bus.MemRead  : 4'b0000;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    latch_en = 1'b0;
    use_live = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (NO_WAIT) begin
            complete = 1'b1;
            use_live = 1'b1;
          end else begin
            stall    = 1'b1;
            latch_en = 1'b1;
            cnt_d    = CNT_INIT;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q    <= 4'b0000;
      wr_q    <= 4'b0000;
      sx_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (latch_en) begin
      rd_q    <= live_rd;
      wr_q    <= live_wr;
      sx_q    <= bus.MemSignExtend;
      addr_q  <= bus.Addr;
      wdata_q <= bus.WriteData;
    end
  end

  // Completing access: live inputs when there are no wait states, else the latched copy.
  always_comb begin
    c_rd    = use_live ? live_rd           : rd_q;
    c_wr    = use_live ? live_wr           : wr_q;
    c_sx    = use_live ? bus.MemSignExtend : sx_q;
    c_addr  = use_live ? bus.Addr          : addr_q;
    c_wdata = use_live ? bus.WriteData     : wdata_q;
  end

  assign off            = c_addr[1:0];
  assign idx            = c_addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = &{1'b0, c_addr[31:ADDR_WIDTH+2]};

  always_comb begin
    c_size = (c_wr != 4'b0000) ? c_wr : c_rd;
    mis    = ((c_size == 4'b1111) && (off != 2'b00)) ||
             ((c_size == 4'b0011) && off[0]);
  end

  assign be       = c_wr << off;
  assign wdata_sh = c_wdata << {off, 3'b000};
  assign we       = complete && (c_wr != 4'b0000) && !mis;

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign rword = mem[idx];
  assign rsh   = rword >> {off, 3'b000};

  always_comb begin
    case (c_rd)
      4'b0001: ld = {{24{c_sx & rsh[7]}},  rsh[7:0]};
      4'b0011: ld = {{16{c_sx & rsh[15]}}, rsh[15:0]};
      default: ld = rsh;
    endcase
  end

  // Outputs are forced quiet while reset is held, even if the master keeps a request up.
  assign bus.Stall      = reset && stall;
  assign bus.Misaligned = reset && complete && mis;
  assign bus.ReadData   = (reset && complete && (c_rd != 4'b0000) && !mis) ? ld : 32'd0;
  assign dbg_state_o    = (state_q == S_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance and a zero-wait instance.
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  logic dbg_a, dbg_b;
  int   errors;
  int   checks;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_a (
    .clock(clk), .reset(rst_n), .bus(ifa), .dbg_state_o(dbg_a)
  );
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
    .clock(clk), .reset(rst_n), .bus(ifb), .dbg_state_o(dbg_b)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] rdata;
    logic        mis;
  } vec_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_a(input logic [3:0] rd, input logic [3:0] wr, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wdata);
    ifa.MemRead = rd; ifa.MemWrite = wr; ifa.MemSignExtend = sx;
    ifa.Addr = addr; ifa.WriteData = wdata;
  endtask

  task automatic drive_b(input logic [3:0] rd, input logic [3:0] wr, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wdata);
    ifb.MemRead = rd; ifb.MemWrite = wr; ifb.MemSignExtend = sx;
    ifb.Addr = addr; ifb.WriteData = wdata;
  endtask

  // Presents one request on dut_a, holds it while Stall=1, and reports what it saw.
  task automatic do_access(input vec_t v, output int stalls, output logic [31:0] rdata,
                           output logic mis, output logic [31:0] rdata_after,
                           output logic mis_after, output bit timeout);
    @(posedge clk); #1;
    drive_a(v.rd, v.wr, v.sx, v.addr, v.wdata);
    stalls = 0; timeout = 1'b1; rdata = 32'hx; mis = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.Stall === 1'b1) stalls++;
      else begin
        rdata = ifa.ReadData; mis = ifa.Misaligned; timeout = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    drive_a(4'b0, 4'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rdata_after = ifa.ReadData; mis_after = ifa.Misaligned;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_a(4'b0, 4'b0, 1'b0, 32'd0, 32'd0);
    drive_b(4'b0, 4'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.Stall, ifa.Misaligned, dbg_a} !== 3'b000) begin
      errors++; $display("FAIL reset_a_flags: got %b want 000", {ifa.Stall, ifa.Misaligned, dbg_a});
    end
    checks++;
    if (ifa.ReadData !== 32'd0) begin
      errors++; $display("FAIL reset_a_rdata: got %h want 00000000", ifa.ReadData);
    end
    checks++;
    if ({ifb.Stall, ifb.Misaligned, dbg_b} !== 3'b000 || ifb.ReadData !== 32'd0) begin
      errors++; $display("FAIL reset_b: got %b/%h want 000/00000000",
                         {ifb.Stall, ifb.Misaligned, dbg_b}, ifb.ReadData);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_accesses(input string name, input vec_t v[$]);
    int st; logic [31:0] rd, rd_after; logic m, m_after; bit to;
    foreach (v[i]) begin
      do_access(v[i], st, rd, m, rd_after, m_after, to);
      checks++;
      if (to || st !== v[i].stalls) begin
        errors++; $display("FAIL %s[%0d] stall_cycles: got %0d (timeout=%0b) want %0d",
                           name, i, st, to, v[i].stalls);
      end
      checks++;
      if (rd !== v[i].rdata) begin
        errors++; $display("FAIL %s[%0d] rdata: got %h want %h", name, i, rd, v[i].rdata);
      end
      checks++;
      if (m !== v[i].mis) begin
        errors++; $display("FAIL %s[%0d] misaligned: got %b want %b", name, i, m, v[i].mis);
      end
      checks++;
      if (rd_after !== 32'd0 || m_after !== 1'b0) begin
        errors++; $display("FAIL %s[%0d] after_completion: got %h/%b want 00000000/0",
                           name, i, rd_after, m_after);
      end
    end
  endtask

  task automatic test_word_rw;
    vec_t v[$];
    v.push_back('{4'b0000, 4'b1111, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0,        1'b0});
    v.push_back('{4'b1111, 4'b0000, 1'b0, 32'h10, 32'h0,        2, 32'hDEADBEEF, 1'b0});
    test_accesses("word_rw", v);
  endtask

  task automatic test_byte_half_lanes;
    vec_t v[$];
    v.push_back('{4'b0000, 4'b1111, 1'b0, 32'h10, 32'h11223344, 2, 32'h0,        1'b0});
    v.push_back('{4'b0000, 4'b0001, 1'b0, 32'h13, 32'h00000080, 2, 32'h0,        1'b0});
    v.push_back('{4'b0001, 4'b0000, 1'b1, 32'h13, 32'h0,        2, 32'hFFFFFF80, 1'b0});
    v.push_back('{4'b0001, 4'b0000, 1'b0, 32'h13, 32'h0,        2, 32'h00000080, 1'b0});
    v.push_back('{4'b1111, 4'b0000, 1'b1, 32'h10, 32'h0,        2, 32'h80223344, 1'b0});
    v.push_back('{4'b0001, 4'b0000, 1'b1, 32'h11, 32'h0,        2, 32'h00000033, 1'b0});
    v.push_back('{4'b0000, 4'b1111, 1'b0, 32'h20, 32'h0,        2, 32'h0,        1'b0});
    v.push_back('{4'b0000, 4'b0011, 1'b0, 32'h22, 32'h0000A5A5, 2, 32'h0,        1'b0});
    v.push_back('{4'b0011, 4'b0000, 1'b1, 32'h22, 32'h0,        2, 32'hFFFFA5A5, 1'b0});
    v.push_back('{4'b0011, 4'b0000, 1'b0, 32'h22, 32'h0,        2, 32'h0000A5A5, 1'b0});
    v.push_back('{4'b1111, 4'b0000, 1'b0, 32'h20, 32'h0,        2, 32'hA5A50000, 1'b0});
    test_accesses("lanes", v);
  endtask

  task automatic test_misaligned_and_decode;
    vec_t v[$];
    v.push_back('{4'b0000, 4'b1111, 1'b0, 32'h30,   32'h01020304, 2, 32'h0,        1'b0});
    v.push_back('{4'b0000, 4'b1111, 1'b0, 32'h31,   32'hFFFFFFFF, 2, 32'h0,        1'b1});
    v.push_back('{4'b1111, 4'b0000, 1'b0, 32'h30,   32'h0,        2, 32'h01020304, 1'b0});
    v.push_back('{4'b0011, 4'b0000, 1'b1, 32'h33,   32'h0,        2, 32'h0,        1'b1});
    v.push_back('{4'b0011, 4'b0000, 1'b0, 32'h31,   32'h0,        2, 32'h0,        1'b1});
    v.push_back('{4'b0001, 4'b0000, 1'b1, 32'h33,   32'h0,        2, 32'h00000001, 1'b0});
    v.push_back('{4'b1111, 4'b0000, 1'b0, 32'h1010, 32'h0,        2, 32'h80223344, 1'b0});
    v.push_back('{4'b1111, 4'b1111, 1'b0, 32'h50,   32'h55AA55AA, 2, 32'h0,        1'b0});
    v.push_back('{4'b1111, 4'b0000, 1'b0, 32'h50,   32'h0,        2, 32'h55AA55AA, 1'b0});
    v.push_back('{4'b0101, 4'b0000, 1'b0, 32'h50,   32'h0,        0, 32'h0,        1'b0});
    v.push_back('{4'b0000, 4'b0111, 1'b0, 32'h50,   32'h0,        0, 32'h0,        1'b0});
    v.push_back('{4'b1111, 4'b0000, 1'b0, 32'h50,   32'h0,        2, 32'h55AA55AA, 1'b0});
    test_accesses("misalign_decode", v);
  endtask

  task automatic test_reset_mid_access;
    vec_t v[$];
    v.push_back('{4'b0000, 4'b1111, 1'b0, 32'h40, 32'h0, 2, 32'h0, 1'b0});
    test_accesses("reset_mid_pre", v);
    @(posedge clk); #1;
    drive_a(4'b0000, 4'b1111, 1'b0, 32'h40, 32'h12345678);
    @(negedge clk);
    checks++;
    if (ifa.Stall !== 1'b1) begin
      errors++; $display("FAIL reset_mid first_stall: got %b want 1", ifa.Stall);
    end
    @(posedge clk); #2;
    checks++;
    if ({ifa.Stall, dbg_a} !== 2'b11) begin
      errors++; $display("FAIL reset_mid second_stall: got %b want 11", {ifa.Stall, dbg_a});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.Stall, ifa.Misaligned, dbg_a} !== 3'b000 || ifa.ReadData !== 32'd0) begin
      errors++; $display("FAIL reset_mid drop: got %b/%h want 000/00000000",
                         {ifa.Stall, ifa.Misaligned, dbg_a}, ifa.ReadData);
    end
    drive_a(4'b0, 4'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v.delete();
    v.push_back('{4'b1111, 4'b0000, 1'b0, 32'h40, 32'h0, 2, 32'h0, 1'b0});
    test_accesses("reset_mid_post", v);
  endtask

  task automatic test_zero_wait;
    int stall_seen;
    stall_seen = 0;
    @(posedge clk); #1;
    drive_b(4'b0000, 4'b1111, 1'b0, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    if (ifb.Stall !== 1'b0) stall_seen++;
    checks++;
    if (ifb.ReadData !== 32'd0) begin
      errors++; $display("FAIL zw_store rdata: got %h want 00000000", ifb.ReadData);
    end
    @(posedge clk); #1;
    drive_b(4'b1111, 4'b0000, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    if (ifb.Stall !== 1'b0) stall_seen++;
    checks++;
    if (ifb.ReadData !== 32'hCAFEF00D) begin
      errors++; $display("FAIL zw_load rdata: got %h want cafef00d", ifb.ReadData);
    end
    @(posedge clk); #1;
    drive_b(4'b1111, 4'b1111, 1'b0, 32'h44, 32'h0BADC0DE);
    @(negedge clk);
    if (ifb.Stall !== 1'b0) stall_seen++;
    checks++;
    if (ifb.ReadData !== 32'd0 || ifb.Misaligned !== 1'b0) begin
      errors++; $display("FAIL zw_both rdata/mis: got %h/%b want 00000000/0",
                         ifb.ReadData, ifb.Misaligned);
    end
    @(posedge clk); #1;
    drive_b(4'b1111, 4'b0000, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    if (ifb.Stall !== 1'b0) stall_seen++;
    checks++;
    if (ifb.ReadData !== 32'h0BADC0DE) begin
      errors++; $display("FAIL zw_both_readback: got %h want 0badc0de", ifb.ReadData);
    end
    @(posedge clk); #1;
    drive_b(4'b0000, 4'b1111, 1'b0, 32'h45, 32'hFFFFFFFF);
    @(negedge clk);
    if (ifb.Stall !== 1'b0) stall_seen++;
    checks++;
    if (ifb.Misaligned !== 1'b1) begin
      errors++; $display("FAIL zw_misaligned: got %b want 1", ifb.Misaligned);
    end
    @(posedge clk); #1;
    drive_b(4'b1111, 4'b0000, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    if (ifb.Stall !== 1'b0) stall_seen++;
    checks++;
    if (ifb.ReadData !== 32'h0BADC0DE || ifb.Misaligned !== 1'b0) begin
      errors++; $display("FAIL zw_after_misaligned: got %h/%b want 0badc0de/0",
                         ifb.ReadData, ifb.Misaligned);
    end
    checks++;
    if (stall_seen !== 0) begin
      errors++; $display("FAIL zw_stall_cycles: got %0d want 0", stall_seen);
    end
    @(posedge clk); #1;
    drive_b(4'b0, 4'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    repeat (2) @(posedge clk);
    test_word_rw();
    test_byte_half_lanes();
    test_misaligned_and_decode();
    test_reset_mid_access();
    test_zero_wait();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
